// File: rtl/hall_light_pkg.sv
// Shared types and constants for the hall lighting scheduler.
// Sizing helpers keep the stagger/hold counters as narrow as their reload values allow.
package hall_light_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        HOLD
    } state_t;

    localparam int DEFAULT_NUM_ZONES       = 5;
    localparam int DEFAULT_PEOPLE_PER_ZONE = 6;
    localparam int DEFAULT_MAX_COUNT       = 30;

    // Width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hall_zone_pwm.sv
// Free-running PWM counter shared by all zones, gated per zone by zone_en.
// Outputs are registered so the zone drive lines are glitch-free.
module hall_zone_pwm
    import hall_light_pkg::*;
#(
    parameter int NUM_ZONES = DEFAULT_NUM_ZONES,
    parameter int PWM_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_ZONES-1:0] zone_en,
    input  logic [PWM_BITS-1:0]  brightness,
    output logic [NUM_ZONES-1:0] zone_pwm
);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            zone_pwm <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            zone_pwm <= zone_en & {NUM_ZONES{pwm_cnt < brightness}};
        end
    end

endmodule

// File: rtl/hall_light_scheduler.sv
// Staggered zone sequencer: occupancy count -> target zones -> one switch per stagger interval.
// Optional HALL_MANUAL_OVERRIDE_EN adds force_on, which targets every zone and suppresses HOLD.
module hall_light_scheduler
    import hall_light_pkg::*;
#(
    parameter int NUM_ZONES           = DEFAULT_NUM_ZONES,
    parameter int PEOPLE_PER_ZONE     = DEFAULT_PEOPLE_PER_ZONE,
    parameter int MAX_COUNT           = DEFAULT_MAX_COUNT,
    parameter int STAGGER_CYCLES      = 1_000_000,
    parameter int VACANCY_HOLD_CYCLES = 500_000_000,
    parameter int PWM_BITS            = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           occupancy_count,
    input  logic [PWM_BITS-1:0]  brightness,
`ifdef HALL_MANUAL_OVERRIDE_EN
    input  logic                 force_on,
`endif
    output logic [NUM_ZONES-1:0] zone_en,
    output logic [NUM_ZONES-1:0] zone_pwm,
    output logic                 busy,
    output logic                 hold_active
);

    localparam int ZW = $clog2(NUM_ZONES + 1);
    localparam int SW = cnt_width(STAGGER_CYCLES);
    localparam int HW = cnt_width(VACANCY_HOLD_CYCLES);
    localparam logic [SW-1:0] STAGGER_LOAD = SW'(STAGGER_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD    = HW'(VACANCY_HOLD_CYCLES - 1);
    localparam logic [ZW-1:0] ZONE_ONE     = ZW'(1);
    localparam logic [ZW-1:0] ZONE_ALL     = ZW'(NUM_ZONES);

    state_t        state;
    logic [ZW-1:0] zones_on;
    logic [ZW-1:0] target_d;
    logic [ZW-1:0] target_q;
    logic [ZW-1:0] target_eff;
    logic [SW-1:0] stagger_cnt;
    logic [HW-1:0] hold_cnt;
    logic [4:0]    count_clamped;
    logic [5:0]    target_wide;

    function automatic logic [NUM_ZONES-1:0] thermo(input logic [ZW-1:0] n);
        logic [NUM_ZONES-1:0] t;
        t = '0;
        for (int i = 0; i < NUM_ZONES; i++) t[i] = (ZW'(i) < n);
        return t;
    endfunction

    // NOTE: every signal written in always_comb gets a value on every path, else a latch is inferred.
    always_comb begin
        count_clamped = (occupancy_count > 5'(MAX_COUNT)) ? 5'(MAX_COUNT) : occupancy_count;
        target_wide   = (6'(count_clamped) + 6'(PEOPLE_PER_ZONE - 1)) / 6'(PEOPLE_PER_ZONE);
        target_d      = (target_wide > 6'(NUM_ZONES)) ? ZONE_ALL : target_wide[ZW-1:0];
    end

`ifdef HALL_MANUAL_OVERRIDE_EN
    assign target_eff = force_on ? ZONE_ALL : target_q;
`else
    assign target_eff = target_q;
`endif

    // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            zones_on    <= '0;
            target_q    <= '0;
            stagger_cnt <= '0;
            hold_cnt    <= '0;
            zone_en     <= '0;
            busy        <= 1'b0;
            hold_active <= 1'b0;
        end else begin
            target_q <= target_d;
            case (state)
                IDLE, RAMP_UP, RAMP_DOWN: begin
                    if (state != IDLE && stagger_cnt != '0) begin
                        stagger_cnt <= stagger_cnt - SW'(1);
                    end else if (target_eff > zones_on) begin
                        zones_on    <= zones_on + ZONE_ONE;
                        zone_en     <= thermo(zones_on + ZONE_ONE);
                        stagger_cnt <= STAGGER_LOAD;
                        state       <= RAMP_UP;
                        busy        <= 1'b1;
                    end else if (state == IDLE && target_eff == '0 && zones_on != '0) begin
                        // Empty hall: keep the lights up for the vacancy delay first.
                        hold_cnt    <= HOLD_LOAD;
                        state       <= HOLD;
                        busy        <= 1'b1;
                        hold_active <= 1'b1;
                    end else if (target_eff < zones_on) begin
                        zones_on    <= zones_on - ZONE_ONE;
                        zone_en     <= thermo(zones_on - ZONE_ONE);
                        stagger_cnt <= STAGGER_LOAD;
                        state       <= RAMP_DOWN;
                        busy        <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (target_eff != '0) begin
                        // Someone came back: cancel without touching zones; IDLE resolves it.
                        state       <= IDLE;
                        busy        <= 1'b0;
                        hold_active <= 1'b0;
                    end else if (hold_cnt == '0) begin
                        zones_on    <= zones_on - ZONE_ONE;
                        zone_en     <= thermo(zones_on - ZONE_ONE);
                        stagger_cnt <= STAGGER_LOAD;
                        state       <= RAMP_DOWN;
                        hold_active <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    hold_active <= 1'b0;
                end
            endcase
        end
    end

    hall_zone_pwm #(
        .NUM_ZONES (NUM_ZONES),
        .PWM_BITS  (PWM_BITS)
    ) u_zone_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .zone_en    (zone_en),
        .brightness (brightness),
        .zone_pwm   (zone_pwm)
    );

endmodule
